// File: rtl/tdes_decrypt_ctrl_if.sv
// Handshake and DES-core bus bundle for the 3DES decrypt controller.
// The master modport is the controller's view; the slave modport is its environment.
interface tdes_decrypt_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] cipher_in;
    logic [63:0] key1;
    logic [63:0] key2;
    logic [63:0] key3;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plain_out;
    logic        out_error;
    logic        busy;
    logic        des_reset;
    logic [63:0] des_data_in;
    logic [63:0] des_key;
    logic        des_decrypt;
    logic        des_done;
    logic [63:0] des_data_out;

    modport master (
        input  in_valid, cipher_in, key1, key2, key3, out_ready, des_done, des_data_out,
        output in_ready, out_valid, plain_out, out_error, busy,
               des_reset, des_data_in, des_key, des_decrypt
    );

    modport slave (
        output in_valid, cipher_in, key1, key2, key3, out_ready, des_done, des_data_out,
        input  in_ready, out_valid, plain_out, out_error, busy,
               des_reset, des_data_in, des_key, des_decrypt
    );
endinterface

// File: rtl/tdes_decrypt_ctrl.sv
// 3DES-EDE decrypt sequencer: runs D(K3), E(K2), D(K1) on one shared iterative
// DES core and returns the plaintext over a valid/ready handshake.
module tdes_decrypt_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic                clk,
    input  logic                reset,
    tdes_decrypt_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_r;
    logic [1:0]       pass_r;
    logic [CNT_W-1:0] cnt_r;
    logic [63:0]      blk_r;
    logic [63:0]      k1_r;
    logic [63:0]      k2_r;
    logic [63:0]      k3_r;

    // Key and core mode for a pass, packed as {key, decrypt}
    function automatic logic [64:0] pass_cfg(input logic [1:0] p, input logic [63:0] ka,
                                             input logic [63:0] kb, input logic [63:0] kc);
        logic [64:0] cfg;
        case (p)
            2'd0:    cfg = {kc, 1'b1};
            2'd1:    cfg = {kb, 1'b0};
            2'd2:    cfg = {ka, 1'b1};
            default: cfg = {kc, 1'b1};
        endcase
        return cfg;
    endfunction

    // Pass sequencer with all core-facing and handshake outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            pass_r          <= 2'd0;
            cnt_r           <= '0;
            blk_r           <= 64'd0;
            k1_r            <= 64'd0;
            k2_r            <= 64'd0;
            k3_r            <= 64'd0;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.plain_out   <= 64'd0;
            bus.out_error   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.des_reset   <= 1'b1;
            bus.des_data_in <= 64'd0;
            bus.des_key     <= 64'd0;
            bus.des_decrypt <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        blk_r         <= bus.cipher_in;
                        k1_r          <= bus.key1;
                        k2_r          <= bus.key2;
                        k3_r          <= bus.key3;
                        pass_r        <= 2'd0;
                        bus.out_error <= 1'b0;
                        bus.in_ready  <= 1'b0;
                        bus.busy      <= 1'b1;
                        state_r       <= LOAD;
                    end
                end
                LOAD: begin
                    // Core operands latch here and stay put for the whole pass
                    bus.des_data_in                  <= blk_r;
                    {bus.des_key, bus.des_decrypt}   <= pass_cfg(pass_r, k1_r, k2_r, k3_r);
                    cnt_r                            <= '0;
                    bus.des_reset                    <= 1'b0;
                    state_r                          <= RUN;
                end
                RUN: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (bus.des_done) begin
                        blk_r         <= bus.des_data_out;
                        bus.des_reset <= 1'b1;
                        if (pass_r == 2'd2) begin
                            bus.plain_out <= bus.des_data_out;
                            bus.out_valid <= 1'b1;
                            state_r       <= OUT;
                        end else begin
                            pass_r  <= pass_r + 2'd1;
                            state_r <= LOAD;
                        end
                    end else if (cnt_r == CNT_LAST) begin
                        // Core hung: abandon the block and report it
                        blk_r         <= 64'd0;
                        bus.plain_out <= 64'd0;
                        bus.out_error <= 1'b1;
                        bus.out_valid <= 1'b1;
                        bus.des_reset <= 1'b1;
                        state_r       <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state_r       <= IDLE;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.des_reset <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tdes_decrypt_ctrl.sv
// Bench for tdes_decrypt_ctrl: a behavioural DES core with per-pass latency
// drives the controller; expectations come from a plain-DES reference model.
module tb_tdes_decrypt_ctrl;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tdes_decrypt_ctrl_if itf();

    tdes_decrypt_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (itf.master)
    );

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                                16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                                  60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,
                                  61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                  41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SBOX [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,3,5,6,11,0};

    // Textbook single-block DES; dec=1 runs the key schedule backwards
    function automatic logic [63:0] des(input logic [63:0] key, input logic [63:0] din, input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [63:0] ipd, pre, res;
        logic [31:0] l, r, f, sout, tmp;
        logic [47:0] e;
        logic [5:0]  six;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int rn = 0; rn < 16; rn++) begin
            for (int s = 0; s < SH_T[rn]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[rn][47-i] = cd[56-PC2_T[i]];
        end
        for (int i = 0; i < 64; i++) ipd[63-i] = din[64-IP_T[i]];
        l = ipd[63:32];
        r = ipd[31:0];
        for (int rn = 0; rn < 16; rn++) begin
            for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
            e = e ^ (dec ? ks[15-rn] : ks[rn]);
            for (int s = 0; s < 8; s++) begin
                six = e[47-6*s -: 6];
                sout[31-4*s -: 4] = 4'(SBOX[s*64 + 16*{six[5], six[0]} + 32'(six[4:1])]);
            end
            for (int i = 0; i < 32; i++) f[31-i] = sout[32-P_T[i]];
            tmp = r;
            r   = l ^ f;
            l   = tmp;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
        return res;
    endfunction

    function automatic logic [63:0] ref3(input logic [63:0] c, input logic [63:0] k1,
                                         input logic [63:0] k2, input logic [63:0] k3);
        return des(k1, des(k2, des(k3, c, 1'b1), 1'b0), 1'b1);
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural core: done rises lat_a[pass] RUN cycles after reset release
    int          cyc_n = 0;
    int          cyc = 0;
    int          pidx = 0;
    bit          run_seen = 1'b0;
    int          lat_a [3] = '{1, 1, 1};
    logic [63:0] seen_key [3];
    logic [63:0] seen_din [3];
    logic        seen_dec [3];
    int          seen_cnt = 0;
    logic [63:0] junk = 64'd0;

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        junk  <= {$urandom, $urandom};
        if (!reset && itf.in_valid && itf.in_ready) begin
            pidx     <= 0;
            run_seen <= 1'b0;
            seen_cnt <= 0;
            cyc      <= 0;
        end else if (itf.des_reset) begin
            cyc <= 0;
            if (run_seen) begin
                pidx     <= pidx + 1;
                run_seen <= 1'b0;
            end
        end else begin
            if (!run_seen) begin
                run_seen <= 1'b1;
                if (seen_cnt < 3) begin
                    seen_key[seen_cnt] <= itf.des_key;
                    seen_din[seen_cnt] <= itf.des_data_in;
                    seen_dec[seen_cnt] <= itf.des_decrypt;
                    seen_cnt           <= seen_cnt + 1;
                end
            end
            if (cyc < 1000) cyc <= cyc + 1;
        end
    end

    assign itf.des_done     = (itf.des_reset === 1'b0) && (cyc >= lat_a[(pidx > 2) ? 2 : pidx] - 1);
    assign itf.des_data_out = itf.des_done ? des(itf.des_key, itf.des_data_in, itf.des_decrypt) : junk;

    task automatic send(input logic [63:0] c, input logic [63:0] k1, input logic [63:0] k2,
                        input logic [63:0] k3, input int l0, input int l1, input int l2,
                        output int t_acc);
        int w = 0;
        while (itf.in_ready !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check_eq("in_ready_before_send", 64'(itf.in_ready), 64'd1);
        lat_a[0] = l0;
        lat_a[1] = l1;
        lat_a[2] = l2;
        itf.cipher_in = c;
        itf.key1 = k1;
        itf.key2 = k2;
        itf.key3 = k3;
        itf.in_valid = 1'b1;
        @(posedge clk);
        #1;
        t_acc = cyc_n;
    endtask

    task automatic expect_blk(input logic [63:0] c, input logic [63:0] k1, input logic [63:0] k2,
                              input logic [63:0] k3, input int l0, input int l1, input int l2,
                              input int t_acc, output logic [63:0] exp_p, output logic exp_e);
        int lat [3];
        int exp_lat = 0;
        int fail_p = 3;
        int npass;
        int w = 0;
        logic [63:0] exp_key [3];
        logic [63:0] exp_din [3];
        lat = '{l0, l1, l2};
        for (int p = 0; p < 3; p++) begin
            if (fail_p == 3) begin
                if (lat[p] > TO) begin
                    fail_p = p;
                    exp_lat += 1 + TO;
                end else begin
                    exp_lat += 1 + lat[p];
                end
            end
        end
        exp_e = (fail_p < 3);
        exp_p = exp_e ? 64'd0 : ref3(c, k1, k2, k3);
        npass = exp_e ? fail_p + 1 : 3;
        exp_key = '{k3, k2, k1};
        exp_din[0] = c;
        exp_din[1] = des(k3, c, 1'b1);
        exp_din[2] = des(k2, exp_din[1], 1'b0);
        do begin
            @(negedge clk);
            w++;
            if (itf.out_valid !== 1'b1) begin
                itf.in_valid  = 1'($urandom_range(0, 1));
                itf.cipher_in = {$urandom, $urandom};
                itf.key1      = {$urandom, $urandom};
                itf.key3      = {$urandom, $urandom};
            end
        end while (itf.out_valid !== 1'b1 && w < 1000);
        itf.in_valid = 1'b0;
        check_eq("out_valid", 64'(itf.out_valid), 64'd1);
        check_eq("latency", 64'(cyc_n - t_acc), 64'(exp_lat));
        check_eq("plain_out", itf.plain_out, exp_p);
        check_eq("out_error", 64'(itf.out_error), 64'(exp_e));
        check_eq("busy_out", 64'(itf.busy), 64'd1);
        check_eq("pass_count", 64'(seen_cnt), 64'(npass));
        for (int p = 0; p < npass; p++) begin
            check_eq($sformatf("pass%0d_key", p), seen_key[p], exp_key[p]);
            check_eq($sformatf("pass%0d_decrypt", p), 64'(seen_dec[p]), 64'(p != 1));
            check_eq($sformatf("pass%0d_data_in", p), seen_din[p], exp_din[p]);
        end
    endtask

    task automatic drain(input int hold, input logic [63:0] exp_p, input logic exp_e, input bit offer,
                         input logic [63:0] c, input logic [63:0] k1, input logic [63:0] k2,
                         input logic [63:0] k3, input int l0, input int l1, input int l2);
        if (offer) begin
            lat_a[0] = l0;
            lat_a[1] = l1;
            lat_a[2] = l2;
            itf.cipher_in = c;
            itf.key1 = k1;
            itf.key2 = k2;
            itf.key3 = k3;
            itf.in_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_plain", itf.plain_out, exp_p);
            check_eq("hold_error", 64'(itf.out_error), 64'(exp_e));
            check_eq("hold_valid", 64'(itf.out_valid), 64'd1);
            check_eq("hold_in_ready", 64'(itf.in_ready), 64'd0);
        end
        itf.out_ready = 1'b1;
        @(negedge clk);
        itf.out_ready = 1'b0;
        check_eq("idle_in_ready", 64'(itf.in_ready), 64'd1);
        check_eq("idle_out_valid", 64'(itf.out_valid), 64'd0);
        check_eq("idle_busy", 64'(itf.busy), 64'd0);
        check_eq("idle_des_reset", 64'(itf.des_reset), 64'd1);
    endtask

    task automatic check_reset_state();
        check_eq("rst_in_ready", 64'(itf.in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(itf.out_valid), 64'd0);
        check_eq("rst_busy", 64'(itf.busy), 64'd0);
        check_eq("rst_des_reset", 64'(itf.des_reset), 64'd1);
        check_eq("rst_des_decrypt", 64'(itf.des_decrypt), 64'd1);
        check_eq("rst_des_key", itf.des_key, 64'd0);
        check_eq("rst_des_data_in", itf.des_data_in, 64'd0);
        check_eq("rst_plain_out", itf.plain_out, 64'd0);
        check_eq("rst_out_error", 64'(itf.out_error), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] kb, cb, c, k1, k2, k3, c2, k21, k22, k23, ep;
        logic        ee;
        int          t;
        kb = 64'hAABB09182736CCDD;
        cb = 64'hC0B7A8D05F3A829C;
        reset = 1'b1;
        itf.in_valid = 1'b0;
        itf.out_ready = 1'b0;
        itf.cipher_in = 64'd0;
        itf.key1 = 64'd0;
        itf.key2 = 64'd0;
        itf.key3 = 64'd0;
        repeat (2) @(negedge clk);
        check_reset_state();
        reset = 1'b0;

        // Known-answer vector with identical keys
        send(cb, kb, kb, kb, 17, 17, 17, t);
        expect_blk(cb, kb, kb, kb, 17, 17, 17, t, ep, ee);
        check_eq("basic_vector", itf.plain_out, 64'h123456ABCD132536);
        drain(0, ep, ee, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1, 1, 1);

        // Distinct keys, then 10 cycles of back-pressure with a second block offered
        c = {$urandom, $urandom}; k1 = {$urandom, $urandom};
        k2 = {$urandom, $urandom}; k3 = {$urandom, $urandom};
        c2 = {$urandom, $urandom}; k21 = {$urandom, $urandom};
        k22 = {$urandom, $urandom}; k23 = {$urandom, $urandom};
        send(c, k1, k2, k3, 17, 17, 17, t);
        expect_blk(c, k1, k2, k3, 17, 17, 17, t, ep, ee);
        drain(10, ep, ee, 1'b1, c2, k21, k22, k23, 5, 9, 3);
        send(c2, k21, k22, k23, 5, 9, 3, t);
        expect_blk(c2, k21, k22, k23, 5, 9, 3, t, ep, ee);
        drain(0, ep, ee, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1, 1, 1);

        // Hung core on the first pass, then a normal block
        send(c, k1, k2, k3, 500, 3, 3, t);
        expect_blk(c, k1, k2, k3, 500, 3, 3, t, ep, ee);
        drain(2, ep, ee, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1, 1, 1);
        send(c, k1, k2, k3, 4, 6, 2, t);
        expect_blk(c, k1, k2, k3, 4, 6, 2, t, ep, ee);
        drain(0, ep, ee, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1, 1, 1);

        // Done on the very last allowed cycle, and a hang on the last pass
        send(c2, k21, k22, k23, TO, TO, TO, t);
        expect_blk(c2, k21, k22, k23, TO, TO, TO, t, ep, ee);
        drain(1, ep, ee, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1, 1, 1);
        send(c2, k21, k22, k23, 5, 7, TO + 1, t);
        expect_blk(c2, k21, k22, k23, 5, 7, TO + 1, t, ep, ee);
        drain(0, ep, ee, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1, 1, 1);

        // Reset while the second pass is running
        send(c, k1, k2, k3, 10, 10, 10, t);
        @(negedge clk);
        itf.in_valid = 1'b0;
        repeat (14) @(negedge clk);
        check_eq("midrun_des_reset", 64'(itf.des_reset), 64'd0);
        check_eq("midrun_pass", 64'(pidx), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        send(cb, kb, kb, kb, 12, 8, 15, t);
        expect_blk(cb, kb, kb, kb, 12, 8, 15, t, ep, ee);
        check_eq("post_reset_vector", itf.plain_out, 64'h123456ABCD132536);
        drain(0, ep, ee, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1, 1, 1);

        // Randomized blocks, latencies and back-pressure
        for (int i = 0; i < 20; i++) begin
            int l [3];
            for (int p = 0; p < 3; p++) begin
                int r;
                r = int'($urandom_range(0, 15));
                l[p] = (r == 0) ? 100 : (r == 1) ? TO : int'($urandom_range(1, 20));
            end
            c = {$urandom, $urandom}; k1 = {$urandom, $urandom};
            k2 = {$urandom, $urandom}; k3 = {$urandom, $urandom};
            send(c, k1, k2, k3, l[0], l[1], l[2], t);
            expect_blk(c, k1, k2, k3, l[0], l[1], l[2], t, ep, ee);
            drain(int'($urandom_range(0, 3)), ep, ee, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1, 1, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
